// File: rtl/aes_decipher.sv
// aes_decipher: iterative AES inverse cipher, one round per clock, for
// AES-128 (Nr=10) and AES-256 (Nr=14). Round keys come from an external
// key-expansion memory that is addressed by the `round` output.
module aes_decipher (
  input  logic         clk,
  input  logic         rst,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_INIT  = 2'd1;
  localparam logic [1:0] S_MAIN  = 2'd2;
  localparam logic [1:0] S_FINAL = 2'd3;

  // Inverse S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  logic [1:0]   state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [3:0]   ctr_q, ctr_d;
  logic [3:0]   nr_q, nr_d;
  logic [127:0] nb_q, nb_d;
  logic [127:0] sr_sb;

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = 11'd2040 - {x, 3'b000};
    return INV_SBOX_TBL[idx +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] b2, b4, b8, r;
    b2 = xt(b);
    b4 = xt(b2);
    b8 = xt(b4);
    r  = (c[0] ? b : 8'h00) ^ (c[1] ? b2 : 8'h00) ^
         (c[2] ? b4 : 8'h00) ^ (c[3] ? b8 : 8'h00);
    return r;
  endfunction

  // Byte k of the state is [127-8k -: 8]; index = row + 4*column.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      o[127 - 8*k -: 8] = inv_sbox(s[127 - 8*k -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9);
      o[119 - 32*c -: 8] = gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd);
      o[111 - 32*c -: 8] = gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb);
      o[103 - 32*c -: 8] = gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he);
    end
    return o;
  endfunction

  // Next-state logic: sequencing, round counter and datapath.
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    ctr_d   = ctr_q;
    nr_d    = nr_q;
    nb_d    = nb_q;
    sr_sb   = inv_sub_bytes(inv_shift_rows(st_q));
    case (state_q)
      S_IDLE: begin
        if (next) begin
          st_d    = block;
          nr_d    = keylen ? 4'd14 : 4'd10;
          ctr_d   = nr_d;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        st_d    = st_q ^ round_key;
        ctr_d   = nr_q - 4'd1;
        state_d = S_MAIN;
      end
      S_MAIN: begin
        st_d = inv_mix_columns(sr_sb ^ round_key);
        if (ctr_q == 4'd1) begin
          ctr_d   = '0;
          state_d = S_FINAL;
        end else begin
          ctr_d = ctr_q - 4'd1;
        end
      end
      default: begin
        nb_d    = sr_sb ^ round_key;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      st_q    <= '0;
      ctr_q   <= '0;
      nr_q    <= '0;
      nb_q    <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      ctr_q   <= ctr_d;
      nr_q    <= nr_d;
      nb_q    <= nb_d;
    end
  end

  // Output decodes from registered state.
  always_comb begin
    case (state_q)
      S_INIT:  round = nr_q;
      S_MAIN:  round = ctr_q;
      default: round = '0;
    endcase
    ready     = (state_q == S_IDLE);
    new_block = nb_q;
  end

endmodule

// File: tb/tb_aes_decipher.sv
// tb_aes_decipher: directed checks of aes_decipher against FIPS-197 C.1/C.3,
// with a bench-side key expansion driving round_key from `round`.
module tb_aes_decipher;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         next = 1'b0;
  logic         keylen = 1'b0;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [127:0] block = '0;
  logic [127:0] new_block;
  logic         ready;

  logic         use256 = 1'b0;
  logic [127:0] rk128 [16];
  logic [127:0] rk256 [16];
  logic [127:0] last_pt = '0;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

  typedef struct {
    logic         kl;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  vec_t vecs [2];

  aes_decipher dut (
    .clk       (clk),
    .rst       (rst),
    .next      (next),
    .keylen    (keylen),
    .round     (round),
    .round_key (round_key),
    .block     (block),
    .new_block (new_block),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  assign round_key = use256 ? rk256[round] : rk128[round];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box from first principles: GF inverse then affine map.
  function automatic logic [7:0] f_sbox(input logic [7:0] a);
    logic [7:0] inv, s, rot;
    inv = '0;
    for (int b = 1; b < 256; b++) begin
      if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
    end
    s   = inv;
    rot = inv;
    for (int i = 0; i < 4; i++) begin
      rot = {rot[6:0], rot[7]};
      s   = s ^ rot;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {f_sbox(w[31:24]), f_sbox(w[23:16]), f_sbox(w[15:8]), f_sbox(w[7:0])};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic kl, input logic [127:0] ct, input logic [127:0] pt,
                        input bit disturb);
    int nr;
    nr = kl ? 14 : 10;
    chk("ready_before_start", 128'(ready), 128'd1);
    next   = 1'b1;
    keylen = kl;
    block  = ct;
    use256 = kl;
    step();
    next = 1'b0;
    for (int k = 0; k <= nr; k++) begin
      chk("round_seq", 128'(round), 128'(nr - k));
      chk("ready_busy", 128'(ready), 128'd0);
      chk("new_block_hold", new_block, last_pt);
      if (disturb && k == 4) begin
        next   = 1'b1;
        keylen = ~kl;
        block  = '1;
      end
      if (disturb && k == 5) next = 1'b0;
      step();
    end
    chk("ready_done", 128'(ready), 128'd1);
    chk("round_idle", 128'(round), 128'd0);
    chk("plaintext", new_block, pt);
    last_pt = pt;
  endtask

  initial begin
    logic [31:0]  w [60];
    logic [255:0] key;
    logic [31:0]  tmp;
    logic [7:0]   rc;
    int           nk, nr;
    bit           hit;

    // Key expansion for both key sizes.
    for (int pass = 0; pass < 2; pass++) begin
      nk  = pass ? 8 : 4;
      nr  = pass ? 14 : 10;
      key = pass ? 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f
                 : {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
      rc  = 8'h01;
      for (int i = 0; i < 60; i++) w[i] = '0;
      for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
      for (int i = nk; i < 4*(nr + 1); i++) begin
        tmp = w[i-1];
        if (i % nk == 0) begin
          tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
          rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end else if (nk > 6 && i % nk == 4) begin
          tmp = subword(tmp);
        end
        w[i] = w[i-nk] ^ tmp;
      end
      for (int r = 0; r < 16; r++) begin
        if (r <= nr) begin
          if (pass == 0) rk128[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
          else           rk256[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end else begin
          if (pass == 0) rk128[r] = '0;
          else           rk256[r] = '0;
        end
      end
    end
    chk("key128_round10", rk128[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    vecs[0] = '{kl: 1'b0, ct: CT128, pt: PT};
    vecs[1] = '{kl: 1'b1, ct: CT256, pt: PT};

    // Reset held for two cycles.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_ready", 128'(ready), 128'd1);
    chk("rst_round", 128'(round), 128'd0);
    chk("rst_new_block", new_block, 128'd0);

    // Reset wins over a simultaneous start.
    rst  = 1'b1;
    next = 1'b1;
    block = CT128;
    step();
    rst  = 1'b0;
    next = 1'b0;
    chk("rst_next_ready", 128'(ready), 128'd1);
    step();
    chk("rst_next_still_idle", 128'(ready), 128'd1);

    // Table-driven known-answer decrypts.
    for (int v = 0; v < 2; v++) begin
      run_op(vecs[v].kl, vecs[v].ct, vecs[v].pt, 1'b0);
    end

    // Inputs disturbed while busy are ignored.
    run_op(1'b0, CT128, PT, 1'b1);
    step();

    // Mid-operation reset at round 5, then a clean AES-256 run.
    next   = 1'b1;
    keylen = 1'b0;
    block  = CT128;
    use256 = 1'b0;
    step();
    next = 1'b0;
    hit  = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (round == 4'd5) hit = 1'b1;
      else step();
    end
    chk("reached_round5", 128'(hit), 128'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_ready", 128'(ready), 128'd1);
    chk("midrst_round", 128'(round), 128'd0);
    chk("midrst_new_block", new_block, 128'd0);
    last_pt = '0;
    run_op(1'b1, CT256, PT, 1'b0);

    // Back-to-back: second start in the first ready cycle.
    run_op(1'b0, CT128, PT, 1'b0);
    run_op(1'b1, CT256, PT, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
